// File: rtl/cordic_nco.sv
// Full-circle sine/cosine NCO: quadrant fold, unrolled CORDIC rotation,
// then unfold to saturated signed I/Q.
module cordic_nco #(
   parameter int DATA_W  = 12,
   parameter int PHASE_W = 16,
   parameter int STAGES  = DATA_W,
   parameter int GUARD   = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ce,
   input  logic               mode,
   input  logic               valid_in,
   input  logic [PHASE_W-1:0] fcw,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               phase_clr,
   output logic [DATA_W-1:0]  x,
   output logic [DATA_W-1:0]  y,
   output logic               valid_out
);

   localparam int IW = DATA_W + GUARD + 2;
   localparam int MAXV = 2 ** (DATA_W - 1) - 1;
   localparam int X0 =
      $rtoi(real'(MAXV) * 0.6072529 + 0.5) * (2 ** GUARD);

   localparam logic signed [IW:0] HALF = (IW+1)'((2 ** GUARD) / 2);
   localparam logic signed [IW:0] HI = (IW+1)'(MAXV);
   localparam logic signed [IW:0] LO = -HI;

   // atan(2^-i) in turns, scaled by 2^32
   localparam logic [31:0] ATAN32 [32] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   function automatic logic [PHASE_W-1:0] atan_q(input int i);
      logic [32:0] t;
      int sh;
      sh = 32 - PHASE_W;
      t = {1'b0, ATAN32[i[4:0]]};
      if (sh > 0) t = (t + (33'd1 << (sh - 1))) >> sh;
      return t[PHASE_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] rnd(
      input logic signed [IW-1:0] v
   );
      logic signed [IW:0] e;
      e = {v[IW-1], v};
      e = (e + HALF) >>> GUARD;
      if (e > HI) return HI[DATA_W-1:0];
      if (e < LO) return LO[DATA_W-1:0];
      return e[DATA_W-1:0];
   endfunction

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] p;
   logic vp;

   logic signed [IW-1:0] xs [0:STAGES];
   logic signed [IW-1:0] ys [0:STAGES];
   logic signed [PHASE_W-1:0] zs [0:STAGES-1];
   logic [1:0] qs [0:STAGES];
   logic vs [0:STAGES];

   logic signed [DATA_W-1:0] c, s, xo, yo;

   // sample uses the accumulator value from before this cycle's update
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         p <= '0;
         vp <= 1'b0;
         xs[0] <= '0;
         ys[0] <= '0;
         zs[0] <= '0;
         qs[0] <= '0;
         vs[0] <= 1'b0;
      end else if (ce) begin
         if (phase_clr)
            acc <= '0;
         else if (!mode && valid_in)
            acc <= acc + fcw;
         p <= mode ? phase_in : acc + phase_in;
         vp <= valid_in;
         qs[0] <= p[PHASE_W-1 -: 2];
         zs[0] <= {2'b00, p[PHASE_W-3:0]};
         xs[0] <= IW'(X0);
         ys[0] <= '0;
         vs[0] <= vp;
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam logic [PHASE_W-1:0] AT = atan_q(i);
      logic neg;
      assign neg = zs[i][PHASE_W-1];

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            xs[i+1] <= '0;
            ys[i+1] <= '0;
            qs[i+1] <= '0;
            vs[i+1] <= 1'b0;
         end else if (ce) begin
            xs[i+1] <= neg ? xs[i] + (ys[i] >>> i)
                           : xs[i] - (ys[i] >>> i);
            ys[i+1] <= neg ? ys[i] - (xs[i] >>> i)
                           : ys[i] + (xs[i] >>> i);
            qs[i+1] <= qs[i];
            vs[i+1] <= vs[i];
         end
      end

      if (i < STAGES - 1) begin : g_z
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)
               zs[i+1] <= '0;
            else if (ce)
               zs[i+1] <= neg ? zs[i] + AT : zs[i] - AT;
         end
      end
   end

   always_comb begin
      c = rnd(xs[STAGES]);
      s = rnd(ys[STAGES]);
      xo = c;
      yo = s;
      unique case (qs[STAGES])
         2'd0: begin xo = c; yo = s; end
         2'd1: begin xo = -s; yo = c; end
         2'd2: begin xo = -c; yo = -s; end
         default: begin xo = s; yo = -c; end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
         valid_out <= 1'b0;
      end else if (ce) begin
         if (vs[STAGES]) begin
            x <= xo;
            y <= yo;
            valid_out <= 1'b1;
         end else begin
            x <= '0;
            y <= '0;
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cordic_nco.sv
// Directed bench for cordic_nco: fixed angles, NCO streams, ce gaps,
// accumulator clear/wrap and mid-stream reset.
module tb_cordic_nco;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic ce = 1'b0;
   logic mode = 1'b0;
   logic valid_in = 1'b0;
   logic phase_clr = 1'b0;
   logic [15:0] fcw = '0;
   logic [15:0] phase_in = '0;
   logic [11:0] x, y;
   logic valid_out;

   int total = 0;
   int bad = 0;

   logic [15:0] expq [$];
   int obsx [$];
   int obsy [$];
   logic [15:0] macc = '0;
   int lx = 0;
   int ly = 0;
   int lv = 0;
   int seen_min = 0;

   always #5 clock = ~clock;

   cordic_nco dut (
      .clock(clock),
      .reset(reset),
      .ce(ce),
      .mode(mode),
      .valid_in(valid_in),
      .fcw(fcw),
      .phase_in(phase_in),
      .phase_clr(phase_clr),
      .x(x),
      .y(y),
      .valid_out(valid_out)
   );

   function automatic int ref_cs(logic [15:0] ph, bit sine);
      real a, r;
      a = 6.283185307179586 * real'(ph) / 65536.0;
      r = 2047.0 * (sine ? $sin(a) : $cos(a));
      return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
   endfunction

   task automatic chk(string tag, int got, int exp, int tol);
      total++;
      if (got > exp + tol || got < exp - tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d tol %0d",
                  tag, got, exp, tol);
      end
   endtask

   task automatic cyc();
      logic ce_s;
      logic [15:0] ph;
      @(posedge clock);
      ce_s = ce;
      #1;
      if ($signed(x) == -2048 || $signed(y) == -2048)
         seen_min = 1;
      if (ce_s) begin
         if (valid_out) begin
            if (expq.size() == 0) begin
               chk("spurious", 1, 0, 0);
            end else begin
               ph = expq.pop_front();
               lx = ref_cs(ph, 1'b0);
               ly = ref_cs(ph, 1'b1);
               lv = 1;
               obsx.push_back($signed(x));
               obsy.push_back($signed(y));
               chk("x", $signed(x), lx, 2);
               chk("y", $signed(y), ly, 2);
            end
         end else begin
            lv = 0;
            lx = 0;
            ly = 0;
            chk("idle_x", $signed(x), 0, 0);
            chk("idle_y", $signed(y), 0, 0);
         end
      end else begin
         chk("hold_v", valid_out, lv, 0);
         chk("hold_x", $signed(x), lx, 2);
         chk("hold_y", $signed(y), ly, 2);
      end
   endtask

   task automatic drive(bit v, bit m, logic [15:0] ph,
                        logic [15:0] f, bit clr, bit c);
      valid_in = v;
      mode = m;
      phase_in = ph;
      fcw = f;
      phase_clr = clr;
      ce = c;
      if (c && v)
         expq.push_back(m ? ph : 16'(macc + ph));
      if (c) begin
         if (clr) macc = '0;
         else if (!m && v) macc = macc + f;
      end
      cyc();
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() != 0 && n < 60) begin
         idle(1);
         n++;
      end
      chk("drain", expq.size(), 0, 0);
   endtask

   task automatic one_shot(logic [15:0] ang, int ex, int ey,
                           string tag);
      int n = 1;
      drive(1'b1, 1'b1, ang, 16'h0, 1'b0, 1'b1);
      while (!valid_out && n < 40) begin
         idle(1);
         n++;
      end
      chk({tag, "_lat"}, n, 15, 0);
      chk({tag, "_x"}, $signed(x), ex, 2);
      chk({tag, "_y"}, $signed(y), ey, 2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acc_n;
      int it;
      bit c;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_x", $signed(x), 0, 0);
      chk("rst_y", $signed(y), 0, 0);
      chk("rst_v", valid_out, 0, 0);
      reset = 1'b1;
      idle(2);

      one_shot(16'h0000, 2047, 0, "d0000");
      one_shot(16'h4000, 0, 2047, "d4000");
      one_shot(16'h8000, -2047, 0, "d8000");
      one_shot(16'hC000, 0, -2047, "dC000");
      one_shot(16'h2000, 1447, 1447, "d2000");
      one_shot(16'hE000, 1447, -1447, "dE000");

      for (int k = 0; k < 676; k++)
         drive(1'b1, 1'b1, 16'(k * 97), 16'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 16'hFFFF, 16'h0, 1'b0, 1'b1);
      drain();
      chk("no_min", seen_min, 0, 0);

      drive(1'b0, 1'b0, 16'h0, 16'h0400, 1'b1, 1'b1);
      obsx.delete();
      obsy.delete();
      for (int k = 0; k < 65; k++)
         drive(1'b1, 1'b0, 16'h0, 16'h0400, 1'b0, 1'b1);
      drain();
      chk("nco_n", obsx.size(), 65, 0);
      chk("nco0_x", obsx[0], 2047, 2);
      chk("nco16_x", obsx[16], 0, 2);
      chk("nco16_y", obsy[16], 2047, 2);
      chk("nco32_x", obsx[32], -2047, 2);
      chk("nco64_x", obsx[64], 2047, 2);
      chk("nco64_y", obsy[64], 0, 2);

      drive(1'b0, 1'b0, 16'h0, 16'h0400, 1'b1, 1'b1);
      obsx.delete();
      obsy.delete();
      for (int k = 0; k < 49; k++)
         drive(1'b1, 1'b0, 16'h4000, 16'h0400, 1'b0, 1'b1);
      drain();
      chk("off0_x", obsx[0], 0, 2);
      chk("off0_y", obsy[0], 2047, 2);
      chk("off48_x", obsx[48], 2047, 2);

      drive(1'b0, 1'b0, 16'h0, 16'h0400, 1'b1, 1'b1);
      acc_n = 0;
      it = 0;
      while (acc_n < 64 && it < 400) begin
         c = 1'($urandom_range(0, 1));
         drive(1'b1, 1'b0, 16'h0, 16'h0400, 1'b0, c);
         if (c) acc_n++;
         it++;
      end
      chk("ce_acc", acc_n, 64, 0);
      drain();

      obsx.delete();
      obsy.delete();
      for (int k = 0; k < 10; k++)
         drive(1'b1, 1'b0, 16'h0, 16'h0400, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'h0, 16'h0400, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 16'h0, 16'h0400, 1'b0, 1'b1);
      drain();
      chk("clr_x", obsx[11], 2047, 2);
      chk("clr_y", obsy[11], 0, 2);

      drive(1'b0, 1'b0, 16'h0, 16'hFFFF, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++)
         drive(1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b0, 1'b1);
      drain();

      for (int k = 0; k < 20; k++)
         drive(1'b1, 1'b1, 16'(16'h1000 + k * 16), 16'h0,
               1'b0, 1'b1);
      chk("pre_rst_v", valid_out, 1, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_x", $signed(x), 0, 0);
      chk("mid_rst_y", $signed(y), 0, 0);
      chk("mid_rst_v", valid_out, 0, 0);
      expq.delete();
      lv = 0;
      lx = 0;
      ly = 0;
      #3;
      reset = 1'b1;
      idle(20);
      one_shot(16'h0000, 2047, 0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cordic_nco.md
# cordic_nco

Parametrised full-circle sine/cosine generator that supersedes the fixed 12-bit quadrant-reduction CORDIC wrapper. Takes either an accumulated phase (NCO mode) or a direct binary angle, folds it to the first quadrant from the two phase MSBs, rotates it through an unrolled CORDIC pipeline, and unfolds the result to signed I/Q. It sits between the modulator's symbol/frequency control and the DAC/mixer path.

## Interface
- DATA_W, 12, output width of x/y, signed two's complement
- PHASE_W, 16, phase/angle width; full circle = 2^PHASE_W
- STAGES, DATA_W, number of CORDIC micro-rotation stages, 4..PHASE_W-2
- GUARD, 2, extra internal LSBs on x/y datapath

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  pipeline advance enable; all state holds when 0
- mode  in  1  0 = NCO (phase from accumulator), 1 = direct (phase = phase_in)
- valid_in  in  1  input sample qualifier, sampled when ce=1
- fcw  in  PHASE_W  frequency control word, unsigned, added per accepted NCO sample
- phase_in  in  PHASE_W  direct angle (mode 1) or phase offset added to accumulator (mode 0)
- phase_clr  in  1  synchronous accumulator clear, acts when ce=1
- x  out  DATA_W  cosine output
- y  out  DATA_W  sine output
- valid_out  out  1  x/y hold a valid sample

## Operation
- Accepted sample: ce=1 and valid_in=1. Every ce=1 cycle shifts the pipeline; valid_in travels alongside as a valid bit.
- Accumulator acc (PHASE_W, wraps modulo 2^PHASE_W): on ce=1: phase_clr=1 → acc<=0 (priority over increment); else mode=0 and valid_in=1 → acc<=acc+fcw; otherwise hold. In mode 1 acc holds.
- Stage 0 phase register p: mode 0 → acc+phase_in (value of acc before this cycle's update, modulo 2^PHASE_W); mode 1 → phase_in.
- Fold register: q = p[PHASE_W-1:PHASE_W-2]; z0 = p[PHASE_W-3:0] (range [0°,90°)); x0 = round((2^(DATA_W-1)-1)·0.6072529)·2^GUARD, y0 = 0.
- Stage i (0..STAGES-1): d = (z≥0) ? +1 : −1; x<=x−d·(y>>>i); y<=y+d·(x>>>i); z<=z−d·atan_i, atan_i = round(atan(2^-i)/(2π)·2^PHASE_W), elaboration-time constants; z carried signed, PHASE_W bits.
- q and valid bit delayed in lockstep shift registers (no pointer FIFO).
- Output map (c=x_final, s=y_final after dropping GUARD LSBs with rounding): q0 → (c,s); q1 → (−s,c); q2 → (−c,−s); q3 → (s,−c). Negation and rounding saturate to ±(2^(DATA_W-1)−1); −2^(DATA_W-1) never emitted.
- Output register: valid bit=1 → x,y from map, valid_out=1; valid bit=0 → x=y=0, valid_out=0.
- Mode change takes effect on the next accepted sample; samples already in flight are unaffected.

## Timing
- Reset (reset=0, async): acc, all pipeline data/valid/q registers, x, y, valid_out = 0 immediately; outputs stay 0 until first valid sample emerges.
- Latency: STAGES+3 ce=1 cycles from accepted input to valid_out (phase reg, fold, STAGES rotations, output reg). Default 15.
- ce=0: no register changes, valid_out and x/y hold last value; latency counted in ce=1 cycles only.
- Throughput: one sample per ce=1 cycle, no bubbles.
- Accumulator wrap: acc+fcw overflow discards carry; output continuous across wrap.
- phase_clr and valid_in simultaneous: acc<=0, the sample uses pre-clear acc.
- Reset mid-stream: all in-flight samples discarded; no valid_out until STAGES+3 ce cycles after new accepted input.
- Accuracy: |error| ≤ 2 LSB on x and y for every angle with default parameters.

## Test plan
- Direct mode, phase_in = 0x0000, 0x4000, 0x8000, 0xC000 -> (x,y) ≈ (2047,0), (0,2047), (−2047,0), (0,−2047) ±2 LSB, valid_out 15 cycles after each input.
- Direct mode, phase_in = 0x2000 and 0xE000 -> (1447,1447) and (1447,−1447) ±2; sweep all 65536 angles vs. real sin/cos, max error ≤ 2, no −2048.
- NCO mode, fcw=0x0400, phase_in=0, continuous valid_in -> 64-sample period, sample 16 ≈ (0,2047), sample 64 equals sample 0; phase_in=0x4000 shifts sequence by 16 samples.
- ce toggled pseudo-randomly during NCO stream -> output sequence identical to ce=1 run, x/y/valid_out frozen on ce=0 cycles.
- phase_clr pulse mid-stream, plus fcw=0xFFFF wrap -> next-accepted sample restarts at (2047,0); wrap yields no discontinuity beyond one fcw step.
- Assert reset mid-stream with 10 samples in flight -> x=y=0, valid_out=0 within the same cycle; after release first valid_out exactly 15 ce cycles after first accepted sample.
